// File: rtl/adau_spi_master.sv
// SPI mode-0 serial back end for the ADAU codec control port.
// One 32-bit command per chip-select frame; read commands return the final MISO byte.
module adau_spi_master #(
    parameter int unsigned CLK_DIV = 4,
    parameter int unsigned CS_GAP  = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] command,
    input  logic        command_valid,
    output logic        spi_ready,
    output logic        spi_sclk,
    output logic        spi_mosi,
    output logic        spi_cs_n,
    input  logic        spi_miso,
    output logic [7:0]  read_data,
    output logic        read_valid
);

    localparam int unsigned PH_W  = $clog2(2 * CLK_DIV);
    localparam int unsigned GAP_W = $clog2(CS_GAP);
    localparam int unsigned CNT_W = (PH_W > GAP_W) ? PH_W : GAP_W;

    localparam logic [CNT_W-1:0] HALF_END = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(2 * CLK_DIV - 1);
    localparam logic [CNT_W-1:0] GAP_END  = CNT_W'(CS_GAP - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_HOLD,
        S_GAP
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [4:0]       bit_q, bit_d;
    logic [31:0]      shreg_q, shreg_d;
    logic             rd_q, rd_d;
    logic [7:0]       rx_q, rx_d;
    logic             ready_q, ready_d;
    logic             sclk_q, sclk_d;
    logic             cs_n_q, cs_n_d;
    logic [7:0]       rdata_q, rdata_d;
    logic             rvalid_q, rvalid_d;

    // State and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            bit_q    <= '0;
            shreg_q  <= '0;
            rd_q     <= 1'b0;
            rx_q     <= '0;
            ready_q  <= 1'b1;
            sclk_q   <= 1'b0;
            cs_n_q   <= 1'b1;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            shreg_q  <= shreg_d;
            rd_q     <= rd_d;
            rx_q     <= rx_d;
            ready_q  <= ready_d;
            sclk_q   <= sclk_d;
            cs_n_q   <= cs_n_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        shreg_d  = shreg_q;
        rd_d     = rd_q;
        rx_d     = rx_q;
        ready_d  = ready_q;
        sclk_d   = sclk_q;
        cs_n_d   = cs_n_q;
        rdata_d  = rdata_q;
        rvalid_d = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (command_valid && ready_q) begin
                    state_d = S_SHIFT;
                    shreg_d = command;
                    rd_d    = command[24];
                    cnt_d   = '0;
                    bit_d   = '0;
                    cs_n_d  = 1'b0;
                    ready_d = 1'b0;
                end
            end
            S_SHIFT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == HALF_END) begin
                    sclk_d = 1'b1;
                    rx_d   = {rx_q[6:0], spi_miso};
                end else if (cnt_q == BIT_END) begin
                    // Falling edge: MOSI (shreg MSB) advances; all-zero after the last bit
                    sclk_d  = 1'b0;
                    cnt_d   = '0;
                    shreg_d = {shreg_q[30:0], 1'b0};
                    bit_d   = bit_q + 5'd1;
                    if (bit_q == 5'd31) begin
                        state_d = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == HALF_END) begin
                    state_d = S_GAP;
                    cnt_d   = '0;
                    cs_n_d  = 1'b1;
                    if (rd_q) begin
                        rdata_d  = rx_q;
                        rvalid_d = 1'b1;
                    end
                end
            end
            S_GAP: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == GAP_END) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    ready_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign spi_ready  = ready_q;
    assign spi_sclk   = sclk_q;
    assign spi_mosi   = shreg_q[31];
    assign spi_cs_n   = cs_n_q;
    assign read_data  = rdata_q;
    assign read_valid = rvalid_q;

endmodule
